regfile_wb_arbiter: RTL and testbench

- Owns the register file's single write port and shares it between two writeback requesters: src0 (ALU result path) and src1 (load/memory result path).
- Arbitrates round-robin using valid/ready handshakes. Writes to x0 are squashed.
- Provides a sequenced clear operation that walks x1..x31 writing zero, one register per cycle.
- Sits between the execute/memory writeback stages and the register file write inputs (writeAddr/writeData/writeEnable).

---
 rtl/regfile_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Purpose:
//   Owns the single register-file write port. It shares that port between two
//   writeback requesters, src0 (ALU results) and src1 (load/memory results).
//   Arbitration is round-robin over valid/ready handshakes. Writes to x0 are
//   squashed. A clear sequence zeroes x1..NUM_REGS-1, one register per cycle.
//
// Handshake:
//   A request is transferred on a rising edge where srcN_valid && srcN_ready.
//   srcN_ready is a combinational function of state, both valids and
//   last_grant, and it is asserted only for the granted source. A requester
//   must hold valid, addr and data stable until it sees ready.
//
// Ports:
//   clk, reset_n              rising-edge clock, synchronous active-low reset
//   src0_valid/ready/addr/data  ALU writeback request channel
//   src1_valid/ready/addr/data  load writeback request channel
//   clear_start               request to zero x1..NUM_REGS-1 (sampled in ARB)
//   clear_busy                high while the clear sequence runs
//   clear_done                one-cycle pulse alongside the last clear write
//   rf_writeAddr/Data/Enable  registered register-file write port
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  src0_valid,
    output logic                  src0_ready,
    input  logic [ADDR_WIDTH-1:0] src0_addr,
    input  logic [DATA_WIDTH-1:0] src0_data,
    input  logic                  src1_valid,
    output logic                  src1_ready,
    input  logic [ADDR_WIDTH-1:0] src1_addr,
    input  logic [DATA_WIDTH-1:0] src1_data,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  clear_done,
    output logic [ADDR_WIDTH-1:0] rf_writeAddr,
    output logic [DATA_WIDTH-1:0] rf_writeData,
    output logic                  rf_writeEnable
);

    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG = ADDR_WIDTH'(NUM_REGS - 1);
    localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_cnt;
    logic                  last_grant;   // index of the most recent winner
    logic                  grant0;
    logic                  grant1;

    // Round-robin grant. On contention the source that did not win last time
    // is chosen; last_grant resets to 1 so src0 wins the first contention.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == ARB) begin
            if (src0_valid && src1_valid) begin
                grant0 = last_grant;
                grant1 = ~last_grant;
            end else begin
                grant0 = src0_valid;
                grant1 = src1_valid;
            end
        end
    end

    assign src0_ready = grant0;
    assign src1_ready = grant1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state          <= ARB;
            clear_cnt      <= '0;
            last_grant     <= 1'b1;
            rf_writeAddr   <= '0;
            rf_writeData   <= '0;
            rf_writeEnable <= 1'b0;
            clear_busy     <= 1'b0;
            clear_done     <= 1'b0;
        end else begin
            // Write enable and done are single-cycle strobes; address and
            // data hold their last values when nothing is written.
            rf_writeEnable <= 1'b0;
            clear_done     <= 1'b0;

            case (state)
                ARB: begin
                    // An x0 destination still completes the handshake and
                    // moves last_grant, but never reaches the register file.
                    if (grant0) begin
                        last_grant <= 1'b0;
                        if (src0_addr != '0) begin
                            rf_writeAddr   <= src0_addr;
                            rf_writeData   <= src0_data;
                            rf_writeEnable <= 1'b1;
                        end
                    end else if (grant1) begin
                        last_grant <= 1'b1;
                        if (src1_addr != '0) begin
                            rf_writeAddr   <= src1_addr;
                            rf_writeData   <= src1_data;
                            rf_writeEnable <= 1'b1;
                        end
                    end

                    // A handshake in the same cycle as clear_start is still
                    // issued above; the clear begins with x1 on the next edge.
                    if (clear_start) begin
                        state      <= CLEAR;
                        clear_cnt  <= FIRST_REG;
                        clear_busy <= 1'b1;
                    end
                end

                CLEAR: begin
                    // clear_start is not looked at here, so re-requests
                    // during a clear are dropped rather than queued.
                    rf_writeAddr   <= clear_cnt;
                    rf_writeData   <= '0;
                    rf_writeEnable <= 1'b1;
                    if (clear_cnt == LAST_REG) begin
                        state      <= ARB;
                        clear_cnt  <= '0;
                        clear_busy <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        clear_cnt <= clear_cnt + FIRST_REG;
                    end
                end

                default: begin
                    state <= ARB;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vectors plus a randomized phase.
// A behavioural model evaluated just before each rising edge pushes expected
// writes into exp_q; an independent monitor pops them whenever the DUT
// presents rf_writeEnable.
module tb_regfile_wb_arbiter;
  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          src0_valid;
  logic          src0_ready;
  logic [AW-1:0] src0_addr;
  logic [DW-1:0] src0_data;
  logic          src1_valid;
  logic          src1_ready;
  logic [AW-1:0] src1_addr;
  logic [DW-1:0] src1_data;
  logic          clear_start;
  logic          clear_busy;
  logic          clear_done;
  logic [AW-1:0] rf_writeAddr;
  logic [DW-1:0] rf_writeData;
  logic          rf_writeEnable;

  regfile_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .src0_valid     (src0_valid),
    .src0_ready     (src0_ready),
    .src0_addr      (src0_addr),
    .src0_data      (src0_data),
    .src1_valid     (src1_valid),
    .src1_ready     (src1_ready),
    .src1_addr      (src1_addr),
    .src1_data      (src1_data),
    .clear_start    (clear_start),
    .clear_busy     (clear_busy),
    .clear_done     (clear_done),
    .rf_writeAddr   (rf_writeAddr),
    .rf_writeData   (rf_writeData),
    .rf_writeEnable (rf_writeEnable)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [AW+DW-1:0] exp_q[$];

  // reference model
  logic          m_clear = 1'b0;
  logic [AW-1:0] m_cnt   = '0;
  logic          m_lg    = 1'b1;
  logic          m_done  = 1'b0;
  logic          hs0     = 1'b0;
  logic          hs1     = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model step, evaluated at the falling edge before each rising edge with
  // the inputs already settled.
  task automatic step();
    logic g0;
    logic g1;
    hs0 = 1'b0;
    hs1 = 1'b0;
    if (!reset_n) begin
      m_clear = 1'b0;
      m_cnt   = '0;
      m_lg    = 1'b1;
      m_done  = 1'b0;
      return;
    end
    check("clear_busy", clear_busy, m_clear);
    check("clear_done", clear_done, m_done);
    m_done = 1'b0;
    if (!m_clear) begin
      g0 = src0_valid && (!src1_valid || m_lg);
      g1 = src1_valid && !g0;
      check("src0_ready", src0_ready, g0);
      check("src1_ready", src1_ready, g1);
      if (g0) begin
        hs0  = 1'b1;
        m_lg = 1'b0;
        if (src0_addr != '0) exp_q.push_back({src0_addr, src0_data});
      end else if (g1) begin
        hs1  = 1'b1;
        m_lg = 1'b1;
        if (src1_addr != '0) exp_q.push_back({src1_addr, src1_data});
      end
      if (clear_start) begin
        m_clear = 1'b1;
        m_cnt   = 5'd1;
      end
    end else begin
      check("src0_ready_clear", src0_ready, 1'b0);
      check("src1_ready_clear", src1_ready, 1'b0);
      exp_q.push_back({m_cnt, {DW{1'b0}}});
      if (m_cnt == AW'(NR - 1)) begin
        m_clear = 1'b0;
        m_cnt   = '0;
        m_done  = 1'b1;
      end else begin
        m_cnt = m_cnt + 5'd1;
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (rf_writeEnable === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                 rf_writeAddr, rf_writeData);
      end else begin
        e = exp_q.pop_front();
        if ({rf_writeAddr, rf_writeData} !== e) begin
          fails++;
          $display("FAIL rf_write: got addr %0d data %0h expected addr %0d data %0h",
                   rf_writeAddr, rf_writeData, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cycle();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  int busy_n;
  int done_n;

  initial begin
    reset_n     = 1'b0;
    src0_valid  = 1'b0;
    src0_addr   = '0;
    src0_data   = '0;
    src1_valid  = 1'b0;
    src1_addr   = '0;
    src1_data   = '0;
    clear_start = 1'b0;
    repeat (2) cycle();

    // reset state
    check("rst_we", rf_writeEnable, 1'b0);
    check("rst_addr", rf_writeAddr, 0);
    check("rst_data", rf_writeData, 0);
    check("rst_busy", clear_busy, 1'b0);
    check("rst_done", clear_done, 1'b0);
    reset_n = 1'b1;

    // single src0 write
    src0_valid = 1'b1; src0_addr = 5'd2; src0_data = 64'h0ABCDEFFEDCBA987;
    cycle();
    check("t1_hs0", hs0, 1'b1);
    check("t1_we", rf_writeEnable, 1'b1);
    check("t1_addr", rf_writeAddr, 2);
    check("t1_data", rf_writeData, 64'h0ABCDEFFEDCBA987);
    src0_valid = 1'b0;
    // src1 alone, leaves last_grant at src1
    src1_valid = 1'b1; src1_addr = 5'd7; src1_data = 64'h77;
    cycle();
    check("t1b_hs1", hs1, 1'b1);
    src1_valid = 1'b0;
    cycle();

    // contention: src0, src1, src0, src1
    src0_valid = 1'b1; src0_addr = 5'd3; src0_data = 64'h33;
    src1_valid = 1'b1; src1_addr = 5'd4; src1_data = 64'h44;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t2_hs0", hs0, (i % 2 == 0));
      check("t2_we", rf_writeEnable, 1'b1);
      check("t2_addr", rf_writeAddr, (i % 2 == 0) ? 3 : 4);
    end
    src0_valid = 1'b0; src1_valid = 1'b0;
    cycle();

    // x0 squash on src1, then src0 wins contention
    src1_valid = 1'b1; src1_addr = 5'd0; src1_data = 64'hFFFF;
    cycle();
    check("t3_hs1", hs1, 1'b1);
    check("t3_we", rf_writeEnable, 1'b0);
    src0_valid = 1'b1; src0_addr = 5'd3; src0_data = 64'h333;
    src1_valid = 1'b1; src1_addr = 5'd4; src1_data = 64'h444;
    cycle();
    check("t3_hs0", hs0, 1'b1);
    src0_valid = 1'b0; src1_valid = 1'b0;
    cycle();

    // clear alongside a src0 write
    src0_valid = 1'b1; src0_addr = 5'd5; src0_data = 64'h55;
    clear_start = 1'b1;
    cycle();
    check("t4_hs0", hs0, 1'b1);
    check("t4_addr5", rf_writeAddr, 5);
    check("t4_busy0", clear_busy, 1'b1);
    clear_start = 1'b0;
    src0_addr = 5'd6; src0_data = 64'h66;
    busy_n = 1;
    done_n = 0;
    for (int k = 1; k <= 31; k++) begin
      cycle();
      check("t4_clr_addr", rf_writeAddr, k);
      check("t4_clr_data", rf_writeData, 0);
      check("t4_clr_we", rf_writeEnable, 1'b1);
      check("t4_no_grant", hs0, 1'b0);
      check("t4_done", clear_done, (k == 31));
      if (clear_busy) busy_n++;
      if (clear_done) done_n++;
      clear_start = (k == 10);
    end
    clear_start = 1'b0;
    check("t4_busy_cycles", busy_n, 31);
    check("t4_done_cycles", done_n, 1);
    cycle();
    check("t4_after_hs0", hs0, 1'b1);
    src0_valid = 1'b0;
    cycle();

    // reset in the middle of a clear
    clear_start = 1'b1;
    cycle();
    clear_start = 1'b0;
    done_n = 0;
    for (int g = 0; g < 40 && m_cnt != 5'd10; g++) begin
      cycle();
      if (clear_done) done_n++;
    end
    check("t5_cnt10", m_cnt, 10);
    reset_n = 1'b0;
    cycle();
    check("t5_busy", clear_busy, 1'b0);
    check("t5_we", rf_writeEnable, 1'b0);
    check("t5_done", clear_done, 1'b0);
    check("t5_done_cnt", done_n, 0);
    reset_n = 1'b1;
    src0_valid = 1'b1; src0_addr = 5'd8; src0_data = 64'h88;
    src1_valid = 1'b1; src1_addr = 5'd9; src1_data = 64'h99;
    cycle();
    check("t5_hs0", hs0, 1'b1);
    src0_valid = 1'b0; src1_valid = 1'b0;
    repeat (2) cycle();

    // randomized traffic with occasional clears
    for (int i = 0; i < 1000; i++) begin
      if (!src0_valid || hs0) begin
        src0_valid = 1'($urandom_range(0, 1));
        src0_addr  = 5'($urandom_range(0, 31));
        src0_data  = {$urandom, $urandom};
      end
      if (!src1_valid || hs1) begin
        src1_valid = 1'($urandom_range(0, 1));
        src1_addr  = 5'($urandom_range(0, 31));
        src1_data  = {$urandom, $urandom};
      end
      clear_start = ($urandom_range(0, 149) == 0);
      cycle();
    end
    src0_valid = 1'b0; src1_valid = 1'b0; clear_start = 1'b0;
    repeat (40) cycle();
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
